// File: rtl/target_table_if.sv
// target_table_if: lookup and bulk-load bus of the jump-target table.
//   master : decode / loader side (drives requests and load beats)
//   slave  : target_table side (returns targets and load status)
// Parameters IDX_W (label index width) and TGT_W (target width) must match the table.
interface target_table_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TGT_W = 10
);

  // Lookup request / response
  logic             lk_valid;
  logic [IDX_W-1:0] lk_index;
  logic [TGT_W-1:0] lk_pc;
  logic             lk_ready;
  logic             tgt_valid;
  logic [TGT_W-1:0] Target;
  logic             tgt_miss;

  // Bulk-load stream
  logic             ld_start;
  logic [IDX_W-1:0] ld_base;
  logic [IDX_W:0]   ld_count;
  logic             ld_valid;
  logic [TGT_W-1:0] ld_data;
  logic             ld_ready;
  logic             ld_busy;
  logic             ld_done;

  modport master (
    output lk_valid, lk_index, lk_pc, ld_start, ld_base, ld_count, ld_valid, ld_data,
    input  lk_ready, tgt_valid, Target, tgt_miss, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  lk_valid, lk_index, lk_pc, ld_start, ld_base, ld_count, ld_valid, ld_data,
    output lk_ready, tgt_valid, Target, tgt_miss, ld_ready, ld_busy, ld_done
  );

endinterface

// File: rtl/target_table.sv
// target_table: programmable jump-target table for the branch unit.
// Maps a label index to a branch target with a registered (latency 1) lookup,
// and can be rewritten at run time by a bulk-load stream.
// Ports:
//   Clk     : clock, all state on rising edge
//   Reset_n : asynchronous active-low reset (table returns to RESET_TABLE)
//   bus     : target_table_if.slave (lk_* lookup, tgt_*/Target result, ld_* load stream)
// Parameters: IDX_W, TGT_W, DEPTH (1..2^IDX_W), RESET_TABLE (entry i at [i*TGT_W +: TGT_W]).
// Option: define TARGET_TABLE_PCREL_EN to treat entries as PC-relative offsets
// (Target = lk_pc + entry, modulo 2^TGT_W); otherwise entries are absolute.
module target_table #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TGT_W = 10,
  parameter int unsigned DEPTH = 16,
  parameter logic [DEPTH*TGT_W-1:0] RESET_TABLE = '0
) (
  input logic          Clk,
  input logic          Reset_n,
  target_table_if.slave bus
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             wr_en_c;

  logic [TGT_W-1:0] table_q [DEPTH];

  logic             lk_ready_q, ld_ready_q, ld_busy_q, ld_done_q;
  logic             tgt_valid_q, tgt_miss_q;
  logic [TGT_W-1:0] tgt_q;

  logic             lk_fire_c, lk_miss_c, base_oor_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [TGT_W-1:0] entry_c, tgt_d_c;

  // Lookup decode: out-of-range indices fall back to the last entry
  assign lk_fire_c  = bus.lk_valid & lk_ready_q;
  assign lk_miss_c  = {1'b0, bus.lk_index} >= DEPTH_C;
  assign base_oor_c = {1'b0, bus.ld_base} >= DEPTH_C;
  assign rd_idx_c   = lk_miss_c ? LAST_C : bus.lk_index;
  assign entry_c    = table_q[rd_idx_c];

`ifdef TARGET_TABLE_PCREL_EN
  // Entries are offsets from the PC sampled with the request
  assign tgt_d_c = bus.lk_pc + entry_c;
`else
  logic [TGT_W-1:0] unused_pc;
  assign unused_pc = bus.lk_pc;
  assign tgt_d_c   = entry_c;
`endif

  // State and load-pointer registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic for the load sequencer
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wr_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          addr_d  = base_oor_c ? '0 : bus.ld_base;
          rem_d   = bus.ld_count;
          state_d = (bus.ld_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          wr_en_c = 1'b1;
          addr_d  = (addr_q == LAST_C) ? '0 : addr_q + IDX_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Table storage; reset reloads the compile-time image
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= RESET_TABLE[i*TGT_W +: TGT_W];
      end
    end else if (wr_en_c) begin
      table_q[addr_q] <= bus.ld_data;
    end
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lk_ready_q <= 1'b1;
      ld_ready_q <= 1'b0;
      ld_busy_q  <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      lk_ready_q <= (state_d == IDLE);
      ld_ready_q <= (state_d == LOAD);
      ld_busy_q  <= (state_d != IDLE);
      ld_done_q  <= (state_d == DONE);
    end
  end

  // Lookup result; target and miss hold between valid pulses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tgt_valid_q <= 1'b0;
      tgt_q       <= '0;
      tgt_miss_q  <= 1'b0;
    end else begin
      tgt_valid_q <= lk_fire_c;
      if (lk_fire_c) begin
        tgt_q      <= tgt_d_c;
        tgt_miss_q <= lk_miss_c;
      end
    end
  end

  assign bus.lk_ready  = lk_ready_q;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.ld_busy   = ld_busy_q;
  assign bus.ld_done   = ld_done_q;
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.Target    = tgt_q;
  assign bus.tgt_miss  = tgt_miss_q;

endmodule

// File: tb/tb_target_table.sv
// tb_target_table: randomized self-checking bench for target_table.
// Two tables (DEPTH 16 and DEPTH 9) receive identical stimulus and are checked
// against a transaction-level model of the table contents and handshake timing.
module tb_target_table;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TGT_W = 10;

  function automatic logic [16*TGT_W-1:0] mk_img();
    logic [16*TGT_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*TGT_W +: TGT_W] = TGT_W'((i * 61 + 7) % 1024);
    r[3*TGT_W +: TGT_W] = TGT_W'(133);
    return r;
  endfunction

  localparam logic [16*TGT_W-1:0] IMG16 = mk_img();
  localparam logic [9*TGT_W-1:0]  IMG9  = IMG16[9*TGT_W-1:0];

  logic Clk;
  logic Reset_n;

  target_table_if #(.IDX_W(IDX_W), .TGT_W(TGT_W)) if16 ();
  target_table_if #(.IDX_W(IDX_W), .TGT_W(TGT_W)) if9 ();

  assign if9.lk_valid = if16.lk_valid;
  assign if9.lk_index = if16.lk_index;
  assign if9.lk_pc    = if16.lk_pc;
  assign if9.ld_start = if16.ld_start;
  assign if9.ld_base  = if16.ld_base;
  assign if9.ld_count = if16.ld_count;
  assign if9.ld_valid = if16.ld_valid;
  assign if9.ld_data  = if16.ld_data;

  target_table #(.IDX_W(IDX_W), .TGT_W(TGT_W), .DEPTH(16), .RESET_TABLE(IMG16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if16)
  );

  target_table #(.IDX_W(IDX_W), .TGT_W(TGT_W), .DEPTH(9), .RESET_TABLE(IMG9)) dut9 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if9)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: table contents and the currently held lookup result per instance
  int               dep [2] = '{16, 9};
  logic [TGT_W-1:0] mdl [2][16];
  logic [TGT_W-1:0] exp_tgt [2];
  logic             exp_miss [2];
  logic [TGT_W-1:0] ld_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mdl[k][i] = IMG16[i*TGT_W +: TGT_W];
      exp_tgt[k]  = '0;
      exp_miss[k] = 1'b0;
    end
  endtask

  // Expected result of a lookup against the current model contents
  task automatic calc_lookup(input int idx, input logic [TGT_W-1:0] pc);
    for (int k = 0; k < 2; k++) begin
      logic [TGT_W-1:0] e;
      exp_miss[k] = (idx >= dep[k]);
      e = mdl[k][exp_miss[k] ? dep[k] - 1 : idx];
`ifdef TARGET_TABLE_PCREL_EN
      exp_tgt[k] = TGT_W'(pc + e);
`else
      exp_tgt[k] = e;
`endif
    end
  endtask

  task automatic check_outputs(input string ph, input logic tv, input logic lkr,
                               input logic ldr, input logic busy, input logic done);
    check({ph, "/tv16"},   32'(if16.tgt_valid), 32'(tv));
    check({ph, "/tgt16"},  32'(if16.Target),    32'(exp_tgt[0]));
    check({ph, "/miss16"}, 32'(if16.tgt_miss),  32'(exp_miss[0]));
    check({ph, "/lkr16"},  32'(if16.lk_ready),  32'(lkr));
    check({ph, "/ldr16"},  32'(if16.ld_ready),  32'(ldr));
    check({ph, "/busy16"}, 32'(if16.ld_busy),   32'(busy));
    check({ph, "/done16"}, 32'(if16.ld_done),   32'(done));
    check({ph, "/tv9"},    32'(if9.tgt_valid),  32'(tv));
    check({ph, "/tgt9"},   32'(if9.Target),     32'(exp_tgt[1]));
    check({ph, "/miss9"},  32'(if9.tgt_miss),   32'(exp_miss[1]));
    check({ph, "/lkr9"},   32'(if9.lk_ready),   32'(lkr));
    check({ph, "/ldr9"},   32'(if9.ld_ready),   32'(ldr));
    check({ph, "/busy9"},  32'(if9.ld_busy),    32'(busy));
    check({ph, "/done9"},  32'(if9.ld_done),    32'(done));
  endtask

  // One idle cycle, optionally issuing a lookup
  task automatic step_lookup(input logic v, input int idx, input logic [TGT_W-1:0] pc);
    if16.lk_valid = v;
    if16.lk_index = IDX_W'(idx);
    if16.lk_pc    = pc;
    if (v) calc_lookup(idx, pc);
    tick();
    check_outputs($sformatf("lk%0d", idx), v, 1'b1, 1'b0, 1'b0, 1'b0);
    if16.lk_valid = 1'b0;
  endtask

  // Full load transaction; data comes from ld_q when queued, else random
  task automatic do_load(input int base, input int count, input logic lk_also, input int lk_idx);
    int wa [2];
    int rem;
    logic [TGT_W-1:0] pc;
    pc = TGT_W'($urandom);
    if16.ld_start = 1'b1;
    if16.ld_base  = IDX_W'(base);
    if16.ld_count = (IDX_W + 1)'(count);
    if16.lk_valid = lk_also;
    if16.lk_index = IDX_W'(lk_idx);
    if16.lk_pc    = pc;
    if (lk_also) calc_lookup(lk_idx, pc);
    tick();
    check_outputs("ld_start", lk_also, 1'b0, count != 0, 1'b1, count == 0);
    if16.lk_valid = 1'b0;
    for (int k = 0; k < 2; k++) wa[k] = (base >= dep[k]) ? 0 : base;
    rem = count;
    while (rem > 0) begin
      logic v;
      logic [TGT_W-1:0] d;
      v = (($urandom % 4) != 0);
      d = TGT_W'($urandom);
      if (v && ld_q.size() > 0) d = ld_q.pop_front();
      if16.ld_valid = v;
      if16.ld_data  = d;
      if16.ld_start = 1'($urandom);
      if16.lk_valid = 1'($urandom);
      if16.lk_index = IDX_W'($urandom);
      if (v) begin
        for (int k = 0; k < 2; k++) begin
          mdl[k][wa[k]] = d;
          wa[k] = (wa[k] + 1) % dep[k];
        end
        rem--;
      end
      tick();
      check_outputs("ld_beat", 1'b0, 1'b0, rem != 0, 1'b1, rem == 0);
    end
    if16.ld_start = 1'b0;
    if16.lk_valid = 1'b0;
    if16.ld_valid = 1'($urandom);
    if16.ld_data  = TGT_W'($urandom);
    tick();
    check_outputs("ld_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if16.ld_valid = 1'b0;
  endtask

  initial begin
    Reset_n       = 1'b0;
    if16.lk_valid = 1'b0;
    if16.lk_index = '0;
    if16.lk_pc    = '0;
    if16.ld_start = 1'b0;
    if16.ld_base  = '0;
    if16.ld_count = '0;
    if16.ld_valid = 1'b0;
    if16.ld_data  = '0;
    reset_model();
    repeat (2) tick();
    check_outputs("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    tick();

    step_lookup(1'b1, 3, 10'd0);
    check("img3", 32'(if16.Target), 32'd133);
    step_lookup(1'b1, 12, TGT_W'($urandom));
    step_lookup(1'b1, 8, TGT_W'($urandom));
    for (int i = 0; i < 30; i++) step_lookup(1'($urandom), int'($urandom_range(0, 15)), TGT_W'($urandom));

    // Wrapping load across the end of the table
    ld_q = '{10'd5, 10'd6, 10'd7, 10'd8};
    do_load(14, 4, 1'b0, 0);
    for (int i = 0; i < 4; i++) step_lookup(1'b1, (14 + i) % 16, TGT_W'($urandom));

    // Lookup on the same edge as ld_start sees the old contents
    ld_q = '{10'd99};
    do_load(2, 1, 1'b1, 2);
    step_lookup(1'b1, 2, 10'd0);

    do_load(5, 0, 1'b1, 7);
    do_load(3, 20, 1'b0, 0);
    do_load(15, 3, 1'b1, 15);
    do_load(12, 2, 1'b0, 0);

`ifdef TARGET_TABLE_PCREL_EN
    ld_q = '{10'd1000};
    do_load(1, 1, 1'b0, 0);
    step_lookup(1'b1, 1, 10'd100);
    check("pcrel_wrap", 32'(if16.Target), 32'd76);
`endif

    for (int r = 0; r < 6; r++) begin
      do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 15)));
      for (int i = 0; i < 8; i++) step_lookup(1'($urandom), int'($urandom_range(0, 15)), TGT_W'($urandom));
    end
    for (int i = 0; i < 16; i++) step_lookup(1'b1, i, TGT_W'($urandom));

    // Reset in the middle of a load aborts it and restores the image
    if16.ld_start = 1'b1;
    if16.ld_base  = '0;
    if16.ld_count = 5'd5;
    tick();
    if16.ld_start = 1'b0;
    if16.ld_valid = 1'b1;
    if16.ld_data  = 10'd511;
    repeat (2) tick();
    #2 Reset_n = 1'b0;
    #1;
    reset_model();
    check_outputs("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if16.ld_valid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    check_outputs("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step_lookup(1'b1, i, TGT_W'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
